vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_pkg.sv | 19 +
 rtl/vend_ctrl_coin_detect.sv | 35 +++
 rtl/vend_ctrl.sv | 147 ++++++++++++++
 tb/tb_vend_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending controller.
//   - state_e   : controller state encoding
//   - COIN_50 / COIN_100 : coin values in 50-bani units
//   - CREDIT_W  : width of the credit register
package vend_pkg;

  localparam int unsigned CREDIT_W = 4;

  localparam logic [1:0] COIN_50  = 2'd1;
  localparam logic [1:0] COIN_100 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND,
    ST_CHANGE
  } state_e;

endpackage

// File: rtl/vend_ctrl_coin_detect.sv
// coin_detect: rising-edge detector and value decoder for the two coin sensors.
// Ports:
//   clk        in  clock
//   i_load50   in  50-bani sensor level
//   i_load100  in  100-bani sensor level
//   o_coin_vld out coin event this cycle (combinational)
//   o_coin_val out coin value in 50-bani units (1, 2 or 3 when both edge together)
module coin_detect
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       i_load50,
  input  logic       i_load100,
  output logic       o_coin_vld,
  output logic [1:0] o_coin_val
);

  logic r_prev50;
  logic r_prev100;
  logic w_edge50;
  logic w_edge100;

  // Sampled every cycle, including under reset, so the registers hold the
  // live sensor levels when reset releases and a held coin is not re-counted.
  always_ff @(posedge clk) begin
    r_prev50  <= i_load50;
    r_prev100 <= i_load100;
  end

  assign w_edge50   = i_load50  & ~r_prev50;
  assign w_edge100  = i_load100 & ~r_prev100;
  assign o_coin_vld = w_edge50 | w_edge100;
  assign o_coin_val = (w_edge50 ? COIN_50 : 2'd0) | (w_edge100 ? COIN_100 : 2'd0);

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: two-product vending controller with coin credit and change return.
// Parameters: PRICE_A, PRICE_B, MAX_CREDIT (all in 50-bani units).
// Ports:
//   clk, rst (sync, active high)
//   load50bani, load1leu : coin sensor levels
//   sel_vld, sel_prod    : product select strobe / product (0 = A, 1 = B)
//   disp_ack, chg_ack    : dispenser done / one change coin returned
//   cancel               : refund request (only with VEND_CANCEL_EN defined)
//   credit               : current credit
//   disp_req, prod_id    : dispense request and product being dispensed
//   chg_req              : change-coin request
//   coin_reject, sel_deny: one-cycle pulses
// Build option: define VEND_CANCEL_EN to enable the cancel/refund path.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_A    = 5,
  parameter int unsigned PRICE_B    = 6,
  parameter int unsigned MAX_CREDIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load50bani,
  input  logic                load1leu,
  input  logic                sel_vld,
  input  logic                sel_prod,
  input  logic                disp_ack,
  input  logic                chg_ack,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                disp_req,
  output logic                prod_id,
  output logic                chg_req,
  output logic                coin_reject,
  output logic                sel_deny
);

  state_e              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_disp_req;
  logic                r_prod_id;
  logic                r_chg_req;
  logic                r_coin_reject;
  logic                r_sel_deny;

  logic                w_coin_vld;
  logic [1:0]          w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_ok;
  logic [CREDIT_W-1:0] w_price;
  logic                w_cancel;

  coin_detect u_coin (
    .clk       (clk),
    .i_load50  (load50bani),
    .i_load100 (load1leu),
    .o_coin_vld(w_coin_vld),
    .o_coin_val(w_coin_val)
  );

`ifdef VEND_CANCEL_EN
  assign w_cancel = cancel;
`else
  logic w_cancel_unused;
  assign w_cancel_unused = cancel;
  assign w_cancel        = 1'b0;
`endif

  assign w_sum     = {1'b0, r_credit} + {{(CREDIT_W-1){1'b0}}, w_coin_val};
  assign w_coin_ok = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign w_price   = sel_prod ? CREDIT_W'(PRICE_B) : CREDIT_W'(PRICE_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_credit      <= '0;
      r_disp_req    <= 1'b0;
      r_prod_id     <= 1'b0;
      r_chg_req     <= 1'b0;
      r_coin_reject <= 1'b0;
      r_sel_deny    <= 1'b0;
    end else begin
      r_coin_reject <= 1'b0;
      r_sel_deny    <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_CREDIT: begin
          // Priority: selection, then cancel, then coin. A coin arriving with
          // a selection or cancel is always rejected.
          if (sel_vld) begin
            r_coin_reject <= w_coin_vld;
            if (r_credit >= w_price) begin
              r_credit   <= r_credit - w_price;
              r_prod_id  <= sel_prod;
              r_disp_req <= 1'b1;
              r_state    <= ST_VEND;
            end else begin
              r_sel_deny <= 1'b1;
            end
          end else if (w_cancel && (r_state == ST_CREDIT)) begin
            r_coin_reject <= w_coin_vld;
            r_chg_req     <= 1'b1;
            r_state       <= ST_CHANGE;
          end else if (w_coin_vld) begin
            if (w_coin_ok) begin
              r_credit <= w_sum[CREDIT_W-1:0];
              r_state  <= ST_CREDIT;
            end else begin
              r_coin_reject <= 1'b1;
            end
          end
        end
        ST_VEND: begin
          r_coin_reject <= w_coin_vld;
          if (disp_ack) begin
            r_disp_req <= 1'b0;
            if (r_credit != '0) begin
              r_chg_req <= 1'b1;
              r_state   <= ST_CHANGE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_CHANGE: begin
          r_coin_reject <= w_coin_vld;
          if (chg_ack) begin
            r_credit <= r_credit - CREDIT_W'(1);
            // Last coin: drop the request together with credit reaching zero.
            if (r_credit == CREDIT_W'(1)) begin
              r_chg_req <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign credit      = r_credit;
  assign disp_req    = r_disp_req;
  assign prod_id     = r_prod_id;
  assign chg_req     = r_chg_req;
  assign coin_reject = r_coin_reject;
  assign sel_deny    = r_sel_deny;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: scoreboard bench for vend_ctrl. Transactions push expected
// output events into a queue; a negedge monitor turns DUT output activity
// into events and compares them in order against the queue.
module tb_vend_ctrl;

  localparam int PA   = 5;
  localparam int PB   = 6;
  localparam int MAXC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load50bani = 1'b0;
  logic       load1leu = 1'b0;
  logic       sel_vld = 1'b0;
  logic       sel_prod = 1'b0;
  logic       disp_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] credit;
  logic       disp_req;
  logic       prod_id;
  logic       chg_req;
  logic       coin_reject;
  logic       sel_deny;

  vend_ctrl #(.PRICE_A(PA), .PRICE_B(PB), .MAX_CREDIT(MAXC)) dut (
    .clk        (clk),
    .rst        (rst),
    .load50bani (load50bani),
    .load1leu   (load1leu),
    .sel_vld    (sel_vld),
    .sel_prod   (sel_prod),
    .disp_ack   (disp_ack),
    .chg_ack    (chg_ack),
    .cancel     (cancel),
    .credit     (credit),
    .disp_req   (disp_req),
    .prod_id    (prod_id),
    .chg_req    (chg_req),
    .coin_reject(coin_reject),
    .sel_deny   (sel_deny)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_REJ, EV_DENY, EV_VEND, EV_DONE, EV_CRED, EV_CHGON, EV_CHGOFF} ev_kind_e;
  typedef struct {
    ev_kind_e k;
    int       v;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  m_credit = 0;
  bit  m_vending = 0;

  task automatic push(input ev_kind_e k, input int v);
    ev_t e;
    e.k = k;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic obs(input ev_kind_e k, input int v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event: got %s v=%0d want none at %0t", k.name(), v, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.v != v) begin
        bad++;
        $display("FAIL event: got %s v=%0d want %s v=%0d at %0t",
                 k.name(), v, e.k.name(), e.v, $time);
      end
    end
  endtask

  // Monitor: output activity is reported in a fixed order per sample.
  logic [3:0] p_credit = '0;
  logic       p_disp = 1'b0;
  logic       p_chg = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (coin_reject)          obs(EV_REJ, int'(credit));
      if (sel_deny)             obs(EV_DENY, int'(credit));
      if (disp_req && !p_disp)  obs(EV_VEND, int'(prod_id));
      if (!disp_req && p_disp)  obs(EV_DONE, int'(credit));
      if (credit != p_credit)   obs(EV_CRED, int'(credit));
      if (chg_req && !p_chg)    obs(EV_CHGON, int'(credit));
      if (!chg_req && p_chg)    obs(EV_CHGOFF, int'(credit));
    end
    p_credit = credit;
    p_disp   = disp_req;
    p_chg    = chg_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d events pending, want 0 (next %s v=%0d)",
               exp_q.size(), exp_q[0].k.name(), exp_q[0].v);
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    check("rst_credit", int'(credit), 0);
    check("rst_disp_req", int'(disp_req), 0);
    check("rst_chg_req", int'(chg_req), 0);
    check("rst_prod_id", int'(prod_id), 0);
    check("rst_coin_reject", int'(coin_reject), 0);
    check("rst_sel_deny", int'(sel_deny), 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_credit  = 0;
    m_vending = 0;
    tick();
  endtask

  // v: coin value (0 none, 1 = 50 bani, 2 = 1 leu, 3 = both); sel/p: selection.
  task automatic act(input int v, input bit sel, input bit p);
    int price = p ? PB : PA;
    if (sel) begin
      if (m_credit >= price) begin
        if (v != 0) push(EV_REJ, m_credit - price);
        push(EV_VEND, int'(p));
        push(EV_CRED, m_credit - price);
        m_credit -= price;
        m_vending = 1;
      end else begin
        if (v != 0) push(EV_REJ, m_credit);
        push(EV_DENY, m_credit);
      end
    end else if (v != 0) begin
      if (m_credit + v <= MAXC) begin
        m_credit += v;
        push(EV_CRED, m_credit);
      end else begin
        push(EV_REJ, m_credit);
      end
    end
    load50bani = v[0];
    load1leu   = v[1];
    sel_vld    = sel;
    sel_prod   = p;
    tick();
    load50bani = 1'b0;
    load1leu   = 1'b0;
    sel_vld    = 1'b0;
    tick();
    wait_drain();
  endtask

  task automatic do_change(input int n);
    repeat (n) begin
      disp_ack = 1'b1;
      repeat ($urandom_range(0, 2)) tick();
      disp_ack = 1'b0;
      m_credit--;
      push(EV_CRED, m_credit);
      if (m_credit == 0) push(EV_CHGOFF, 0);
      chg_ack = 1'b1;
      tick();
      chg_ack = 1'b0;
    end
  endtask

  task automatic finish_vend(input bit do_chg);
    repeat ($urandom_range(0, 3)) begin
      if ($urandom_range(0, 1) == 1) begin
        push(EV_REJ, m_credit);
        load1leu = 1'b1;
        sel_vld  = 1'b1;
        chg_ack  = 1'b1;
        tick();
        load1leu = 1'b0;
        sel_vld  = 1'b0;
        chg_ack  = 1'b0;
        tick();
      end else begin
        tick();
      end
    end
    push(EV_DONE, m_credit);
    if (m_credit > 0) push(EV_CHGON, m_credit);
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    if (do_chg && m_credit > 0) do_change(m_credit);
    m_vending = 0;
    wait_drain();
  endtask

  task automatic held_coin();
    if (m_credit + 2 <= MAXC) begin
      m_credit += 2;
      push(EV_CRED, m_credit);
    end else begin
      push(EV_REJ, m_credit);
    end
    load1leu = 1'b1;
    repeat (10) tick();
    load1leu = 1'b0;
    tick();
    wait_drain();
  endtask

  task automatic cancel_req();
`ifdef VEND_CANCEL_EN
    bit go = (m_credit > 0);
    if (go) push(EV_CHGON, m_credit);
`endif
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
`ifdef VEND_CANCEL_EN
    if (go) do_change(m_credit);
`endif
    tick();
    wait_drain();
  endtask

  initial begin
    // Sensor held high across reset must not produce a coin afterwards.
    load1leu = 1'b1;
    reset_dut();
    repeat (3) tick();
    load1leu = 1'b0;
    wait_drain();
    check("idle_credit", int'(credit), 0);

    // 1 leu, 1 leu, 50 bani, select A -> exact vend, back to idle.
    act(2, 0, 0); act(2, 0, 0); act(1, 0, 0);
    check("credit5", int'(credit), 5);
    act(0, 1, 0);
    check("vend_disp_req", int'(disp_req), 1);
    check("vend_prod_a", int'(prod_id), 0);
    finish_vend(1);

    // 3x 1 leu, select A -> one change coin.
    act(2, 0, 0); act(2, 0, 0); act(2, 0, 0);
    act(0, 1, 0);
    finish_vend(1);
    check("after_change_credit", int'(credit), 0);

    // Credit 4, select B -> deny; then ceiling behaviour at 7.
    act(2, 0, 0); act(2, 0, 0);
    act(0, 1, 1);
    check("deny_credit", int'(credit), 4);
    check("deny_no_disp", int'(disp_req), 0);
    act(2, 0, 0); act(1, 0, 0);
    act(2, 0, 0);
    act(1, 0, 0);
    check("ceiling_credit", int'(credit), 8);
    act(1, 1, 1);
    check("vend_prod_b", int'(prod_id), 1);
    finish_vend(1);

    // Simultaneous coin edges, then a held 1-leu level.
    act(3, 0, 0);
    held_coin();
    check("held_credit", int'(credit), 5);
    reset_dut();

`ifdef VEND_CANCEL_EN
    act(2, 0, 0); act(1, 0, 0);
    cancel_req();
    check("cancel_credit", int'(credit), 0);
    act(2, 0, 0); act(1, 0, 0);
    push(EV_CHGON, m_credit);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    do_change(1);
    wait_drain();
    reset_dut();
`else
    act(2, 0, 0); act(1, 0, 0);
    cancel_req();
    check("cancel_ignored", int'(credit), 3);
    reset_dut();
`endif

    // Reset in the middle of a change sequence.
    act(2, 0, 0); act(2, 0, 0); act(2, 0, 0); act(2, 0, 0);
    act(0, 1, 0);
    finish_vend(0);
    do_change(1);
    wait_drain();
    reset_dut();
    tick();
    check("post_rst_chg_req", int'(chg_req), 0);

    // Randomized phase.
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 19);
      if (r < 9) begin
        act($urandom_range(1, 3), 0, 0);
      end else if (r < 14) begin
        act(($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, 1, 1'($urandom_range(0, 1)));
        if (m_vending) finish_vend(1);
      end else if (r < 17) begin
        cancel_req();
      end else if (r < 19) begin
        held_coin();
      end else begin
        reset_dut();
      end
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
